// File: rtl/emern_poly_frontend_v2_pkg.sv
// Shared constants, opcodes and command decode for the polygon SPI frontend.
package emern_poly_frontend_v2_pkg;

   localparam int N_POLY_DEF = 4;
   localparam int WCOLOR_DEF = 6;
   localparam int WPX_DEF    = 7;
   localparam int WPY_DEF    = 6;

   localparam logic [1:0] CMD_WRITE_PFX = 2'b10;
   localparam logic [1:0] CMD_CLEAR_PFX = 2'b01;
   localparam logic [7:0] CMD_SET_BG    = 8'h01;
   localparam logic [7:0] CMD_COMMIT    = 8'h02;
   localparam logic [7:0] CMD_CLR_ERR   = 8'h03;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_WRITE,
      OP_CLEAR,
      OP_SET_BG,
      OP_COMMIT,
      OP_CLR_ERR,
      OP_BAD
   } op_e;

   function automatic int calc_pw(input int wc, input int wx, input int wy);
      return wc + 3 * wx + 3 * wy;
   endfunction

   function automatic op_e decode_op(input logic [7:0] cmd);
      op_e op;
      unique case (1'b1)
         (cmd[7:6] == CMD_WRITE_PFX): op = OP_WRITE;
         (cmd[7:6] == CMD_CLEAR_PFX): op = OP_CLEAR;
         (cmd == CMD_SET_BG):         op = OP_SET_BG;
         (cmd == CMD_COMMIT):         op = OP_COMMIT;
         (cmd == CMD_CLR_ERR):        op = OP_CLR_ERR;
         default:                     op = OP_BAD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/emern_poly_frontend_v2_spi_rx_shift.sv
// SPI receive path: pin synchronisers, edge detect, frame shifter, MISO status shifter.
module emern_poly_frontend_v2_spi_rx_shift
   import emern_poly_frontend_v2_pkg::*;
#(
   parameter int FRAME_BITS = 53
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs_in,
   input  logic                  sck_in,
   input  logic                  mosi_in,
   input  logic                  en_load,
   input  logic [7:0]            status_in,
   output logic                  frame_valid_out,
   output logic [FRAME_BITS-1:0] frame_out,
   output logic                  miso_out
);

   localparam int CW = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
   localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);

   logic [2:0]            cs_q, cs_d;
   logic [2:0]            sck_q, sck_d;
   logic [1:0]            mosi_q, mosi_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic                  fv_q, fv_d;
   logic [7:0]            miso_q, miso_d;

   logic cs_hi;
   logic sck_rise;
   logic sck_fall;
   logic cs_fall;
   logic accept;

   always_comb begin
      cs_d     = {cs_q[1:0], cs_in};
      sck_d    = {sck_q[1:0], sck_in};
      mosi_d   = {mosi_q[0], mosi_in};
      cs_hi    = cs_q[1];
      sck_rise = sck_q[1] & ~sck_q[2];
      sck_fall = ~sck_q[1] & sck_q[2];
      cs_fall  = ~cs_q[1] & cs_q[2];
      accept   = sck_rise & en_load & ~cs_hi & (cnt_q < FULL);
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      fv_d     = 1'b0;
      miso_d   = miso_q;
      if (cs_hi) begin
         cnt_d  = '0;
         sr_d   = '0;
         miso_d = '0;
      end else begin
         // LSB arrives first, so shifting right leaves bit 0 in sr_q[0]
         if (accept) begin
            sr_d  = {mosi_q[1], sr_q[FRAME_BITS-1:1]};
            cnt_d = cnt_q + CW'(1);
            fv_d  = (cnt_q == LAST);
         end
         if (cs_fall) begin
            miso_d = status_in;
         end else if (sck_fall) begin
            miso_d = {1'b0, miso_q[7:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_q   <= 3'b111;
         sck_q  <= '0;
         mosi_q <= '0;
         cnt_q  <= '0;
         sr_q   <= '0;
         fv_q   <= 1'b0;
         miso_q <= '0;
      end else begin
         cs_q   <= cs_d;
         sck_q  <= sck_d;
         mosi_q <= mosi_d;
         cnt_q  <= cnt_d;
         sr_q   <= sr_d;
         fv_q   <= fv_d;
         miso_q <= miso_d;
      end
   end

   assign frame_valid_out = fv_q;
   assign frame_out       = sr_q;
   assign miso_out        = miso_q[0];

endmodule

// File: rtl/emern_poly_frontend_v2.sv
// Double-buffered SPI command frontend: shadow polygon/background registers
// copied to the active set at a frame boundary after COMMIT.
module emern_poly_frontend_v2
   import emern_poly_frontend_v2_pkg::*;
#(
   parameter int N_POLY = N_POLY_DEF,
   parameter int WCOLOR = WCOLOR_DEF,
   parameter int WPX    = WPX_DEF,
   parameter int WPY    = WPY_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cs_in,
   input  logic                     sck_in,
   input  logic                     mosi_in,
   output logic                     miso_out,
   input  logic                     en_load,
   input  logic                     frame_start_in,
   output logic [WCOLOR-1:0]        bg_color_out,
   output logic [WCOLOR*N_POLY-1:0] poly_color_out,
   output logic [WPX*N_POLY-1:0]    v0_x_out,
   output logic [WPX*N_POLY-1:0]    v1_x_out,
   output logic [WPX*N_POLY-1:0]    v2_x_out,
   output logic [WPY*N_POLY-1:0]    v0_y_out,
   output logic [WPY*N_POLY-1:0]    v1_y_out,
   output logic [WPY*N_POLY-1:0]    v2_y_out,
   output logic [N_POLY-1:0]        poly_enable_out,
   output logic                     commit_pending_out,
   output logic                     err_out
);

   localparam int PW         = calc_pw(WCOLOR, WPX, WPY);
   localparam int FRAME_BITS = 8 + PW;
   localparam int SW         = PW + 1;
   localparam int OFF_X0     = WCOLOR;
   localparam int OFF_X1     = OFF_X0 + WPX;
   localparam int OFF_X2     = OFF_X1 + WPX;
   localparam int OFF_Y0     = OFF_X2 + WPX;
   localparam int OFF_Y1     = OFF_Y0 + WPY;
   localparam int OFF_Y2     = OFF_Y1 + WPY;
   localparam logic [6:0] N_POLY_W = 7'(N_POLY);

   logic                  frame_valid;
   logic [FRAME_BITS-1:0] frame;
   logic [7:0]            status;
   logic [7:0]            cmd;
   logic [PW-1:0]         payload;
   logic [5:0]            slot;
   op_e                   op;
   logic                  slot_ok;
   logic                  do_write;
   logic                  do_clear;
   logic                  copy;

   logic              pending_q, pending_d;
   logic              err_q, err_d;
   logic [5:0]        fcnt_q, fcnt_d;
   logic [WCOLOR-1:0] bg_sh_q, bg_sh_d;
   logic [WCOLOR-1:0] bg_act_q, bg_act_d;

   emern_poly_frontend_v2_spi_rx_shift #(
      .FRAME_BITS (FRAME_BITS)
   ) u_rx (
      .clk             (clk),
      .rst_n           (rst_n),
      .cs_in           (cs_in),
      .sck_in          (sck_in),
      .mosi_in         (mosi_in),
      .en_load         (en_load),
      .status_in       (status),
      .frame_valid_out (frame_valid),
      .frame_out       (frame),
      .miso_out        (miso_out)
   );

   assign cmd     = frame[7:0];
   assign payload = frame[FRAME_BITS-1:8];
   assign slot    = cmd[5:0];
   assign status  = {fcnt_q, err_q, pending_q};

   always_comb begin
      op        = decode_op(cmd);
      slot_ok   = ({1'b0, slot} < N_POLY_W);
      do_write  = frame_valid & (op == OP_WRITE) & slot_ok;
      do_clear  = frame_valid & (op == OP_CLEAR) & slot_ok;
      copy      = frame_start_in & pending_q;
      pending_d = pending_q;
      err_d     = err_q;
      fcnt_d    = fcnt_q;
      bg_sh_d   = bg_sh_q;
      bg_act_d  = bg_act_q;
      if (copy) begin
         pending_d = 1'b0;
         bg_act_d  = bg_sh_q;
      end
      // a COMMIT landing on a frame_start cycle re-arms for the next frame
      if (frame_valid) begin
         fcnt_d = fcnt_q + 6'd1;
         unique case (op)
            OP_WRITE, OP_CLEAR: if (!slot_ok) err_d = 1'b1;
            OP_SET_BG:          bg_sh_d   = payload[WCOLOR-1:0];
            OP_COMMIT:          pending_d = 1'b1;
            OP_CLR_ERR:         err_d     = 1'b0;
            default:            err_d     = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
         err_q     <= 1'b0;
         fcnt_q    <= '0;
         bg_sh_q   <= '0;
         bg_act_q  <= '0;
      end else begin
         pending_q <= pending_d;
         err_q     <= err_d;
         fcnt_q    <= fcnt_d;
         bg_sh_q   <= bg_sh_d;
         bg_act_q  <= bg_act_d;
      end
   end

   for (genvar i = 0; i < N_POLY; i++) begin : g_slot
      logic [SW-1:0] sh_q, sh_d;
      logic [SW-1:0] act_q, act_d;

      always_comb begin
         sh_d  = sh_q;
         act_d = act_q;
         if (do_write && slot == 6'(i)) sh_d = {1'b1, payload};
         if (do_clear && slot == 6'(i)) sh_d = '0;
         if (copy) act_d = sh_q;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sh_q  <= '0;
            act_q <= '0;
         end else begin
            sh_q  <= sh_d;
            act_q <= act_d;
         end
      end

      assign poly_color_out[i*WCOLOR +: WCOLOR] = act_q[0 +: WCOLOR];
      assign v0_x_out[i*WPX +: WPX] = act_q[OFF_X0 +: WPX];
      assign v1_x_out[i*WPX +: WPX] = act_q[OFF_X1 +: WPX];
      assign v2_x_out[i*WPX +: WPX] = act_q[OFF_X2 +: WPX];
      assign v0_y_out[i*WPY +: WPY] = act_q[OFF_Y0 +: WPY];
      assign v1_y_out[i*WPY +: WPY] = act_q[OFF_Y1 +: WPY];
      assign v2_y_out[i*WPY +: WPY] = act_q[OFF_Y2 +: WPY];
      assign poly_enable_out[i]     = act_q[PW];
   end

   assign bg_color_out       = bg_act_q;
   assign commit_pending_out = pending_q;
   assign err_out            = err_q;

endmodule

// File: tb/tb_emern_poly_frontend_v2.sv
// Scenario bench for the polygon SPI frontend with a small state model
// and a status-byte scoreboard.
module tb_emern_poly_frontend_v2;

   localparam int NP = 4;
   localparam int WC = 6;
   localparam int WX = 7;
   localparam int WY = 6;
   localparam int PW = WC + 3 * WX + 3 * WY;
   localparam int FB = 8 + PW;
   localparam int VW = WC + NP + NP * WC + 3 * NP * WX + 3 * NP * WY;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cs_in = 1'b1;
   logic sck_in = 1'b0;
   logic mosi_in = 1'b0;
   logic en_load = 1'b1;
   logic frame_start_in = 1'b0;
   logic miso_out;
   logic [WC-1:0]    bg_color_out;
   logic [WC*NP-1:0] poly_color_out;
   logic [WX*NP-1:0] v0_x_out, v1_x_out, v2_x_out;
   logic [WY*NP-1:0] v0_y_out, v1_y_out, v2_y_out;
   logic [NP-1:0]    poly_enable_out;
   logic commit_pending_out;
   logic err_out;
   logic [VW-1:0] dut_vec;

   int checks = 0;
   int errors = 0;

   logic [PW:0]   m_sh [NP];
   logic [PW:0]   m_act [NP];
   logic [WC-1:0] m_bg_sh, m_bg_act;
   logic          m_pend, m_err;
   logic [5:0]    m_cnt;
   logic [9:0]    sb_q [$];

   emern_poly_frontend_v2 dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cs_in              (cs_in),
      .sck_in             (sck_in),
      .mosi_in            (mosi_in),
      .miso_out           (miso_out),
      .en_load            (en_load),
      .frame_start_in     (frame_start_in),
      .bg_color_out       (bg_color_out),
      .poly_color_out     (poly_color_out),
      .v0_x_out           (v0_x_out),
      .v1_x_out           (v1_x_out),
      .v2_x_out           (v2_x_out),
      .v0_y_out           (v0_y_out),
      .v1_y_out           (v1_y_out),
      .v2_y_out           (v2_y_out),
      .poly_enable_out    (poly_enable_out),
      .commit_pending_out (commit_pending_out),
      .err_out            (err_out)
   );

   always #5 clk = ~clk;

   assign dut_vec = {bg_color_out, poly_enable_out, poly_color_out,
                     v0_x_out, v1_x_out, v2_x_out,
                     v0_y_out, v1_y_out, v2_y_out};

   function automatic logic [PW-1:0] mk_pl(
      input logic [WC-1:0] c,
      input logic [WX-1:0] x0, input logic [WY-1:0] y0,
      input logic [WX-1:0] x1, input logic [WY-1:0] y1,
      input logic [WX-1:0] x2, input logic [WY-1:0] y2);
      return {y2, y1, y0, x2, x1, x0, c};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [NP-1:0]    en;
      logic [NP*WC-1:0] c;
      logic [NP*WX-1:0] x0, x1, x2;
      logic [NP*WY-1:0] y0, y1, y2;
      for (int i = 0; i < NP; i++) begin
         c[i*WC +: WC]  = m_act[i][0 +: WC];
         x0[i*WX +: WX] = m_act[i][6 +: WX];
         x1[i*WX +: WX] = m_act[i][13 +: WX];
         x2[i*WX +: WX] = m_act[i][20 +: WX];
         y0[i*WY +: WY] = m_act[i][27 +: WY];
         y1[i*WY +: WY] = m_act[i][33 +: WY];
         y2[i*WY +: WY] = m_act[i][39 +: WY];
         en[i]          = m_act[i][PW];
      end
      return {m_bg_act, en, c, x0, x1, x2, y0, y1, y2};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NP; i++) begin
         m_sh[i]  = '0;
         m_act[i] = '0;
      end
      m_bg_sh  = '0;
      m_bg_act = '0;
      m_pend   = 1'b0;
      m_err    = 1'b0;
      m_cnt    = '0;
   endtask

   task automatic m_pulse();
      if (m_pend) begin
         m_act    = m_sh;
         m_bg_act = m_bg_sh;
         m_pend   = 1'b0;
      end
   endtask

   task automatic m_exec(input logic [7:0] cmd, input logic [PW-1:0] pl);
      m_cnt = m_cnt + 6'd1;
      if (cmd[7:6] == 2'b10 || cmd[7:6] == 2'b01) begin
         if (int'(cmd[5:0]) >= NP) m_err = 1'b1;
         else if (cmd[7]) m_sh[int'(cmd[5:0])] = {1'b1, pl};
         else m_sh[int'(cmd[5:0])] = '0;
      end else if (cmd == 8'h01) m_bg_sh = pl[WC-1:0];
      else if (cmd == 8'h02) m_pend = 1'b1;
      else if (cmd == 8'h03) m_err = 1'b0;
      else m_err = 1'b1;
   endtask

   // bit k of miso is sampled at the end of the SCK low phase of bit k
   task automatic send_bits(input logic [79:0] data, input int n,
                            input bit fs_last, output logic [9:0] rx);
      rx = '0;
      cs_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < n; k++) begin
         mosi_in = data[k];
         repeat (6) @(posedge clk);
         #1;
         if (k < 10) rx[k] = miso_out;
         sck_in = 1'b1;
         if (fs_last && k == n - 1) begin
            repeat (3) @(posedge clk);
            #1;
            frame_start_in = 1'b1;
            @(posedge clk);
            #1;
            frame_start_in = 1'b0;
            repeat (2) @(posedge clk);
            #1;
         end else begin
            repeat (6) @(posedge clk);
            #1;
         end
         sck_in = 1'b0;
      end
      repeat (6) @(posedge clk);
      #1;
      cs_in = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic do_frame(input logic [7:0] cmd, input logic [PW-1:0] pl,
                           input bit fs, input int extra);
      logic [9:0] rx;
      if (fs) m_pulse();
      send_bits({{(80 - FB){1'b0}}, pl, cmd}, FB + extra, fs, rx);
      m_exec(cmd, pl);
   endtask

   task automatic read_status(output logic [9:0] rx);
      send_bits('0, 10, 1'b0, rx);
   endtask

   task automatic pulse_fs();
      frame_start_in = 1'b1;
      @(posedge clk);
      #1;
      frame_start_in = 1'b0;
      m_pulse();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL reset_active got %h want %h", dut_vec, exp_vec());
      end
      checks++;
      if (commit_pending_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_pending got %b want 0", commit_pending_out);
      end
      checks++;
      if (err_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %b want 0", err_out);
      end
      checks++;
      if (miso_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_miso got %b want 0", miso_out);
      end
   endtask

   task automatic test_write_commit();
      logic [PW-1:0] pl;
      pl = mk_pl(6'h2A, 7'd5, 6'd3, 7'd100, 6'd40, 7'd60, 6'd63);
      do_frame(8'h80, pl, 1'b0, 0);
      do_frame(8'h02, '0, 1'b0, 0);
      checks++;
      if (commit_pending_out !== 1'b1) begin
         errors++;
         $display("FAIL wc_pending got %b want 1", commit_pending_out);
      end
      frame_start_in = 1'b1;
      #2;
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL wc_before_pulse got %h want %h", dut_vec, exp_vec());
      end
      @(posedge clk);
      #1;
      frame_start_in = 1'b0;
      m_pulse();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL wc_after_pulse got %h want %h", dut_vec, exp_vec());
      end
      checks++;
      if (poly_enable_out !== 4'b0001) begin
         errors++;
         $display("FAIL wc_enable got %b want 0001", poly_enable_out);
      end
      checks++;
      if ({poly_color_out[5:0], v1_x_out[6:0], v2_y_out[5:0]} !== {6'h2A, 7'd100, 6'd63}) begin
         errors++;
         $display("FAIL wc_fields got %h/%0d/%0d want 2a/100/63",
                  poly_color_out[5:0], v1_x_out[6:0], v2_y_out[5:0]);
      end
      checks++;
      if (commit_pending_out !== 1'b0) begin
         errors++;
         $display("FAIL wc_pending_clr got %b want 0", commit_pending_out);
      end
   endtask

   task automatic test_no_commit();
      do_frame(8'h82, mk_pl(6'h15, 7'd1, 6'd2, 7'd3, 6'd4, 7'd5, 6'd6), 1'b0, 0);
      pulse_fs();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL nc_active got %h want %h", dut_vec, exp_vec());
      end
      checks++;
      if (commit_pending_out !== 1'b0) begin
         errors++;
         $display("FAIL nc_pending got %b want 0", commit_pending_out);
      end
   endtask

   task automatic test_bad_slot();
      do_frame(8'h85, mk_pl(6'h3F, 7'd9, 6'd9, 7'd9, 6'd9, 7'd9, 6'd9), 1'b0, 0);
      checks++;
      if (err_out !== m_err) begin
         errors++;
         $display("FAIL bad_err got %b want %b", err_out, m_err);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL bad_active got %h want %h", dut_vec, exp_vec());
      end
      do_frame(8'h01, mk_pl(6'h11, 7'd0, 6'd0, 7'd0, 6'd0, 7'd0, 6'd0), 1'b0, 0);
      do_frame(8'h03, '0, 1'b0, 0);
      checks++;
      if (err_out !== 1'b0) begin
         errors++;
         $display("FAIL clr_err got %b want 0", err_out);
      end
   endtask

   task automatic test_partial();
      logic [9:0] rx;
      logic [9:0] exp;
      logic [PW-1:0] pl;
      sb_q.push_back({2'b00, m_cnt, m_err, m_pend});
      read_status(rx);
      exp = sb_q.pop_front();
      checks++;
      if (rx !== exp) begin
         errors++;
         $display("FAIL part_status_pre got %b want %b", rx, exp);
      end
      pl = mk_pl(6'h07, 7'd7, 6'd7, 7'd7, 6'd7, 7'd7, 6'd7);
      send_bits({{(80 - FB){1'b0}}, pl, 8'h81}, 30, 1'b0, rx);
      // extra zero bits after a full frame must not form an 8'h00 command
      do_frame(8'h40, '0, 1'b0, 8);
      sb_q.push_back({2'b00, m_cnt, m_err, m_pend});
      read_status(rx);
      exp = sb_q.pop_front();
      checks++;
      if (rx !== exp) begin
         errors++;
         $display("FAIL part_status_post got %b want %b", rx, exp);
      end
      do_frame(8'h02, '0, 1'b0, 0);
      pulse_fs();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL part_active got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_commit_coincident();
      do_frame(8'h81, mk_pl(6'h22, 7'd11, 6'd12, 7'd13, 6'd14, 7'd15, 6'd16), 1'b0, 0);
      do_frame(8'h02, '0, 1'b1, 0);
      checks++;
      if (commit_pending_out !== 1'b1) begin
         errors++;
         $display("FAIL coin_pending got %b want 1", commit_pending_out);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL coin_no_copy got %h want %h", dut_vec, exp_vec());
      end
      pulse_fs();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL coin_copy got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_status();
      logic [9:0] rx;
      logic [9:0] exp;
      fork
         send_bits({{(80 - FB){1'b0}}, mk_pl(6'h01, 7'd1, 6'd1, 7'd1, 6'd1, 7'd1, 6'd1), 8'h80},
                   FB, 1'b0, rx);
         begin
            repeat (300) @(posedge clk);
            #1;
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            m_reset();
         end
      join
      checks++;
      if ({dut_vec, commit_pending_out, err_out} !== {exp_vec(), 2'b00}) begin
         errors++;
         $display("FAIL midreset got %h want %h", dut_vec, exp_vec());
      end
      do_frame(8'h81, mk_pl(6'h05, 7'd2, 6'd2, 7'd2, 6'd2, 7'd2, 6'd2), 1'b0, 0);
      do_frame(8'h83, mk_pl(6'h06, 7'd3, 6'd3, 7'd3, 6'd3, 7'd3, 6'd3), 1'b0, 0);
      do_frame(8'h02, '0, 1'b0, 0);
      sb_q.push_back({2'b00, m_cnt, m_err, m_pend});
      read_status(rx);
      exp = sb_q.pop_front();
      checks++;
      if (rx !== exp) begin
         errors++;
         $display("FAIL status_sb got %b want %b", rx, exp);
      end
      checks++;
      if (rx !== 10'b00_0000_1101) begin
         errors++;
         $display("FAIL status_bits got %b want 0000001101", rx);
      end
      checks++;
      if (miso_out !== 1'b0) begin
         errors++;
         $display("FAIL miso_idle got %b want 0", miso_out);
      end
   endtask

   initial begin
      test_reset();
      test_write_commit();
      test_no_commit();
      test_bad_slot();
      test_partial();
      test_commit_coincident();
      test_status();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/emern_poly_frontend_v2.md
# emern_poly_frontend_v2

Parametrised, double-buffered SPI command frontend for the polygon GPU. Receives LSB-first SPI frames from the host into shadow polygon/background registers. Copies shadow to active registers only at a frame boundary after an explicit COMMIT, so the rasteriser never sees a half-updated scene. Returns a status byte on MISO. Sits between the chip pins and the rasteriser/VGA timing block.

## Interface
Parameters:
- N_POLY, 4, number of polygon slots (1..64)
- WCOLOR, 6, colour width
- WPX, 7, x-coordinate width
- WPY, 6, y-coordinate width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cs_in  in  1  SPI chip select, active-low, asynchronous to clk
- sck_in  in  1  SPI clock (mode 0), asynchronous
- mosi_in  in  1  SPI data, LSB first
- miso_out  out  1  status bit stream
- en_load  in  1  gates SCK rising-edge acceptance (HSYNC window)
- frame_start_in  in  1  one-cycle pulse at start of vertical blank
- bg_color_out  out  WCOLOR  active background colour
- poly_color_out  out  WCOLOR*N_POLY  packed active colours, slot 0 in LSBs
- v{0,1,2}_x_out  out  WPX*N_POLY  packed active x vertices
- v{0,1,2}_y_out  out  WPY*N_POLY  packed active y vertices
- poly_enable_out  out  N_POLY  active per-slot enables
- commit_pending_out  out  1  COMMIT received, not yet applied
- err_out  out  1  sticky error flag

## Operation
- Frame: 8-bit cmd, then payload PW = WCOLOR+3*WPX+3*WPY bits. FRAME_BITS = 8+PW (53 at defaults). Field order from bit 0: cmd, color, v0x, v1x, v2x, v0y, v1y, v2y.
- Commands: 8'b10iiiiii write slot i (shadow fields + shadow enable=1). 8'b01iiiiii clear slot i (shadow fields=0, enable=0). 8'h01 set shadow bg = color field. 8'h02 COMMIT (sets pending). 8'h03 clear err. Other codes: ignored, err<=1. Slot i >= N_POLY: ignored, err<=1. Every command uses the full FRAME_BITS frame; payload is ignored where unused.
- Receive: cs/sck/mosi pass through 2-flop synchronisers. sck_rise is taken from a third flop. A bit is accepted on sck_rise & en_load & ~cs & (count < FRAME_BITS).
- When count reaches FRAME_BITS, exactly one execute cycle occurs. Further bits are discarded until cs goes high.
- cs high at any time: count and shift register clear. A partial frame is dropped with no state change and no error.
- Commit: on frame_start_in with pending=1, all active registers <= shadow and pending<=0.
- Status byte on MISO, LSB first: bit0 pending, bit1 err, bits7:2 = 6-bit executed-frame count (wraps 63->0). The byte is latched when synchronised cs falls. Bit0 is driven immediately; the next bit is driven on each synchronised sck fall. After 8 bits MISO=0. MISO=0 while cs high.

## Timing
- Reset: all shadow and active registers, pending, err, frame count, miso_out = 0.
- Pin-to-accept latency: 3 clk from an sck_in rise to the bit being shifted. SCK high and low phases must each be >= 4 clk.
- Execute cycle: 1 clk after the final bit is shifted. Shadow, pending and err update at the end of the execute cycle.
- Active outputs change only 1 clk after a frame_start_in with pending=1.
- frame_start_in and COMMIT execute in the same cycle: no copy; pending=1 afterwards; the copy happens at the next frame_start_in.
- frame_start_in copy and a shadow write in the same cycle: active takes the pre-write shadow; the write lands in shadow only.
- Reset mid-frame: everything clears; the host frame is lost.

## Structure
- constants.v holds WCOLOR/WPX/WPY/N_POLY defaults, command opcodes and the FRAME_BITS/PW derivation.
- Sub-module emern_spi_rx_shift: synchronisers, edge detect, bit counter, receive shift register, MISO shifter. It outputs a frame_valid pulse and a bit-reversed-corrected buffer.
- Top level contains command decode, shadow/active register arrays (generate over N_POLY), commit logic and status.

## Test plan
- Write slot 0 (cmd 8'h80, color 6'h2A, v0=(5,3), v1=(100,40), v2=(60,63)), then COMMIT, then frame_start_in -> outputs unchanged before the pulse; slot-0 fields and poly_enable_out=4'b0001 one clk after it.
- Write slot 2 without COMMIT, then frame_start_in -> active outputs unchanged, commit_pending_out=0.
- cmd 8'h85 with N_POLY=4 -> err_out=1, no register change. Then cmd 8'h03 -> err_out=0.
- cs high after 30 bits, then a full clear-slot-0 frame -> only the clear executes; frame count increments by 1.
- COMMIT execute coincident with frame_start_in -> pending=1, no copy; the next pulse copies.
- Status read after 3 frames with pending=1 and err=0 -> MISO bits LSB first 1,0,1,1,0,0,0,0.
